// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: sample format, fixed-point scaling and the
// phase codes emitted by the per-stage twiddle/control ROM.
package fft_pkg;

   localparam int WIDTH = 24;
   localparam int FRAC  = 8;

   typedef enum logic [1:0] {
      PH_FILL = 2'd0,
      PH_BFLY = 2'd1,
      PH_TWID = 2'd2,
      PH_RSVD = 2'd3
   } phase_e;

   typedef struct packed {
      logic signed [WIDTH-1:0] re;
      logic signed [WIDTH-1:0] im;
   } cplx_t;

endpackage

// File: rtl/radix2_sdf_stage_if.sv
// Sample/twiddle stream into an SDF stage and the registered stream out of it.
// Streams are unthrottled: in_valid/out_valid qualify data, there is no ready.
interface radix2_sdf_stage_if;
   import fft_pkg::*;

   logic                    in_valid;
   logic signed [WIDTH-1:0] din_r;
   logic signed [WIDTH-1:0] din_i;
   logic [1:0]              state;
   logic signed [WIDTH-1:0] w_r;
   logic signed [WIDTH-1:0] w_i;
   logic                    out_valid;
   logic signed [WIDTH-1:0] dout_r;
   logic signed [WIDTH-1:0] dout_i;

   modport master (
      output in_valid, din_r, din_i, state, w_r, w_i,
      input  out_valid, dout_r, dout_i
   );

   modport slave (
      input  in_valid, din_r, din_i, state, w_r, w_i,
      output out_valid, dout_r, dout_i
   );

endinterface

// File: rtl/cmul_q.sv
// Combinational fixed-point complex multiply: full-precision products, then
// arithmetic shift by FRAC and truncation to WIDTH (floor, wraps, no rounding).
module cmul_q
   import fft_pkg::*;
(
   input  cplx_t a_i,
   input  cplx_t b_i,
   output cplx_t p_o
);

   logic signed [2*WIDTH-1:0] ar_x, ai_x, br_x, bi_x;
   logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [2*WIDTH:0]   re_sum, im_sum;
   logic                      unused_bits;

   assign ar_x = {{WIDTH{a_i.re[WIDTH-1]}}, a_i.re};
   assign ai_x = {{WIDTH{a_i.im[WIDTH-1]}}, a_i.im};
   assign br_x = {{WIDTH{b_i.re[WIDTH-1]}}, b_i.re};
   assign bi_x = {{WIDTH{b_i.im[WIDTH-1]}}, b_i.im};

   assign p_rr = ar_x * br_x;
   assign p_ii = ai_x * bi_x;
   assign p_ri = ar_x * bi_x;
   assign p_ir = ai_x * br_x;

   assign re_sum = {p_rr[2*WIDTH-1], p_rr} - {p_ii[2*WIDTH-1], p_ii};
   assign im_sum = {p_ri[2*WIDTH-1], p_ri} + {p_ir[2*WIDTH-1], p_ir};

   // Taking bits [FRAC +: WIDTH] equals an arithmetic shift then truncation.
   assign p_o.re = re_sum[FRAC+WIDTH-1:FRAC];
   assign p_o.im = im_sum[FRAC+WIDTH-1:FRAC];

   assign unused_bits = ^{re_sum[2*WIDTH:FRAC+WIDTH], re_sum[FRAC-1:0],
                          im_sum[2*WIDTH:FRAC+WIDTH], im_sum[FRAC-1:0]};

endmodule

// File: rtl/radix2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage; phase and twiddle come
// from the stage ROM each cycle, the stage itself keeps no phase counter.
module radix2_sdf_stage #(
   parameter int DELAY = 2
) (
   input logic               clk,
   input logic               rst,
   radix2_sdf_stage_if.slave bus
);
   import fft_pkg::*;

   phase_e phase;
   logic   en;
   logic   out_valid_q, out_valid_d;
   cplx_t  dout_q, dout_d;
   cplx_t  line_q [DELAY];
   cplx_t  line_d [DELAY];
   cplx_t  din_g, fifo_out, fifo_in, bfly_sum, bfly_diff, twid_prod, res;

   assign phase    = phase_e'(bus.state);
   assign fifo_out = line_q[DELAY-1];

   cmul_q u_cmul (
      .a_i (fifo_out),
      .b_i ({bus.w_r, bus.w_i}),
      .p_o (twid_prod)
   );

   always_comb begin
      // Invalid input cycles feed zeros so the ROM phases can drain the line.
      din_g       = bus.in_valid ? {bus.din_r, bus.din_i} : '0;
      en          = bus.in_valid || (phase == PH_BFLY) || (phase == PH_TWID);
      bfly_sum.re  = fifo_out.re + din_g.re;
      bfly_sum.im  = fifo_out.im + din_g.im;
      bfly_diff.re = fifo_out.re - din_g.re;
      bfly_diff.im = fifo_out.im - din_g.im;
      fifo_in     = din_g;
      res         = '0;
      out_valid_d = 1'b0;
      case (phase)
         PH_BFLY: begin
            fifo_in     = bfly_diff;
            res         = bfly_sum;
            out_valid_d = 1'b1;
         end
         PH_TWID: begin
            res         = twid_prod;
            out_valid_d = 1'b1;
         end
         default: ;
      endcase
      dout_d = out_valid_d ? res : dout_q;
      line_d = line_q;
      if (en) begin
         line_d[0] = fifo_in;
         for (int i = 1; i < DELAY; i++) line_d[i] = line_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         for (int i = 0; i < DELAY; i++) line_q[i] <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         for (int i = 0; i < DELAY; i++) line_q[i] <= line_d[i];
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.dout_r    = dout_q.re;
   assign bus.dout_i    = dout_q.im;

endmodule

// File: doc/radix2_sdf_stage.md
Name: radix2_sdf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage of the 1024-point FFT pipeline.
- Consumes the `state`, `w_r` and `w_i` stream produced by the stage twiddle/control ROM, with the matching delay depth.
- Takes a continuous complex sample stream. Performs butterfly add/subtract through a DELAY-deep feedback line, then multiplies each delayed difference by the twiddle.
- Emits a registered complex output stream to the next stage.

Parameters:
- WIDTH, 24: bit width of each real/imag sample and twiddle component (two's complement).
- FRAC, 8: fractional bits of samples and twiddles (1.0 = 0x000100).
- DELAY, 2: feedback delay-line depth in samples. Equals half the butterfly span of this stage.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  din_r/din_i carry a valid sample this cycle.
- din_r  in  WIDTH  input sample, real part.
- din_i  in  WIDTH  input sample, imaginary part.
- state  in  2  stage phase from ROM: 0 = fill, 1 = butterfly, 2 = twiddle; 3 is reserved.
- w_r  in  WIDTH  twiddle, real part, aligned with `state`.
- w_i  in  WIDTH  twiddle, imaginary part, aligned with `state`.
- out_valid  out  1  dout_r/dout_i valid this cycle.
- dout_r  out  WIDTH  output sample, real part.
- dout_i  out  WIDTH  output sample, imaginary part.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Reset values: out_valid = 0, dout_r = 0, dout_i = 0, all delay-line entries = 0.
- Reset asserted mid-operation clears everything immediately. The first post-reset cycle behaves as a cold start.
- Enable: en = in_valid OR (state == 1) OR (state == 2).
- Sample gating: when in_valid = 0, din is treated as 0. This lets the ROM-driven phases drain the line.
- Delay line: DELAY-entry complex shift register, advances only when en = 1. `fifo_out` is the oldest entry; `fifo_in` enters at the head.
- state 0 or 3 (fill/reserved): fifo_in = din. No output; out_valid <= 0 next cycle.
- state 1 (butterfly):
  - fifo_in = fifo_out − din.
  - Output = fifo_out + din.
- state 2 (twiddle):
  - fifo_in = din.
  - Output = fifo_out × (w_r + j·w_i).
- Complex multiply:
  - re = (a_r·w_r − a_i·w_i), im = (a_r·w_i + a_i·w_r).
  - Partial products are full 2·WIDTH signed; the sum is 2·WIDTH+1 bits.
  - Arithmetic shift right by FRAC, then truncate to WIDTH bits.
  - No rounding, no saturation.
- Add/sub: WIDTH-bit two's complement, wraps on overflow, no saturation, no scaling.
- Output register:
  - On every cycle with en = 1 and state ∈ {1, 2}: dout <= result, out_valid <= 1.
  - Otherwise: out_valid <= 0 and dout holds its last value.
- Latency: exactly 1 cycle from the input cycle to the corresponding dout.
- Steady state: the ROM sequence 0 (DELAY cycles), then repeating [1 × DELAY, 2 × DELAY], gives out_valid continuously high from the first state-1 cycle + 1 onward.
- State 2 in the first cycles after reset: outputs the zeroed line contents multiplied by w. Result is 0 with out_valid = 1; legal.
- `state` and `w` are sampled in the same cycle as din. No internal counter; phase control belongs entirely to the ROM.

Decomposition:
- Shared package (fft_pkg):
  - Constants: WIDTH, FRAC, phase codes PH_FILL = 0, PH_BFLY = 1, PH_TWID = 2.
  - Complex sample typedef {re, im}.
- One natural sub-module, cmul_q: combinational complex multiplier implementing the shift/truncate rule, reused by every stage.

Test Plan:
- Reset then idle: rst pulse, in_valid = 0, state = 0 -> out_valid = 0, dout = 0, delay line stays 0.
- Basic frame (DELAY = 2):
  - Stimulus: din = 0x100, 0x200, 0x300, 0x400 (imag 0); states 0,0,1,1,2,2; w = 1,1,1,1,1,−j.
  - Required: out_valid high for 4 cycles starting the cycle after the first state 1.
  - Required dout_r: 0x000400, 0x000600, 0xFFFE00.
  - Final output: dout_r = 0, dout_i = 0x000200.
- Continuous streaming: 3 back-to-back frames of ramp data with ROM phase pattern 1,1,2,2 repeating -> no bubble in out_valid; each frame matches the golden model.
- Wrap/truncation:
  - din = 0x7FFFFF + 0x000001 in state 1 -> dout_r = 0x800000 (wrap).
  - Twiddle 0x000080 (0.5) × 0x000003 -> 0x000001 (truncate toward −∞).
- Async reset mid-frame: assert rst during the second state-1 cycle -> out_valid drops asynchronously, line cleared; the next frame output equals a cold-start frame.
- Drain: in_valid = 0 during a state-2 phase -> outputs are twiddled delayed differences; the line fills with zeros.
